// File: rtl/memory_cycle.sv
// MEM stage: data-memory request/ack handshake with an ack timeout, plus the MEM/WB pipeline register.
// Build option: define MEM_ALIGN_CHECK_EN to add a word-alignment check and the misalign_err output.
module memory_cycle #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [4:0]  WriteRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic        dmem_err,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [31:0] ResultW
);

  typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_e;

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        access, is_load, misalign;
  logic        capture, misalign_cap;

  logic        regwrite_q, memtoreg_q;
  logic [4:0]  writereg_q;
  logic [31:0] readdata_q, aluout_q;

  assign access  = MemtoRegM | MemWriteM;
  assign is_load = access & ~MemWriteM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign     = access & (ALUOutM[1:0] != 2'b00);
  assign misalign_err = misalign_cap;
`else
  assign misalign     = 1'b0;
`endif

  // The bus is driven straight from EX/MEM; upstream holds these stable while StallM=1.
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = ALUOutM;
  assign dmem_wdata = WriteDataM;
  assign dmem_err   = err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    dmem_req     = 1'b0;
    StallM       = 1'b0;
    capture      = 1'b0;
    misalign_cap = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && misalign) begin
          capture      = 1'b1;
          misalign_cap = 1'b1;
        end else if (access) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            capture = 1'b1;
          end else begin
            StallM  = 1'b1;
            state_d = WAIT;
            cnt_d   = '0;
          end
        end else begin
          capture = 1'b1;
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          StallM = 1'b1;
          // cnt_q counts completed WAIT cycles; the last allowed one without ack ends in ERROR.
          if (cnt_q == CNT_LAST) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ERROR: begin
        StallM = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Reset abandons any outstanding access immediately, not just at the edge.
    if (rst) begin
      dmem_req     = 1'b0;
      StallM       = 1'b0;
      capture      = 1'b0;
      misalign_cap = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      writereg_q <= '0;
      readdata_q <= '0;
      aluout_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (capture) begin
        regwrite_q <= RegWriteM & ~misalign_cap;
        memtoreg_q <= MemtoRegM;
        writereg_q <= WriteRegM;
        aluout_q   <= ALUOutM;
        if (misalign_cap) begin
          readdata_q <= '0;
        end else if (is_load) begin
          readdata_q <= dmem_rdata;
        end
      end else if (StallM) begin
        // Bubble: kill the write-back controls, leave the data fields as they were.
        regwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
      end
    end
  end

  assign RegWriteW = regwrite_q;
  assign MemtoRegW = memtoreg_q;
  assign WriteRegW = writereg_q;
  assign ReadDataW = readdata_q;
  assign ALUOutW   = aluout_q;
  assign ResultW   = memtoreg_q ? readdata_q : aluout_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: directed scenarios plus random transactions with random ack delays.
module tb_memory_cycle;
  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM, WriteDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        StallM, dmem_err;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_err;
`endif
  logic        RegWriteW, MemtoRegW;
  logic [4:0]  WriteRegW;
  logic [31:0] ReadDataW, ALUOutW, ResultW;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected MEM/WB contents.
  logic        e_rw, e_m2r;
  logic [4:0]  e_wr;
  logic [31:0] e_rd, e_alu;

  memory_cycle #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .StallM(StallM), .dmem_err(dmem_err),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .WriteRegW(WriteRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    e_rw = 1'b0; e_m2r = 1'b0; e_wr = '0; e_rd = '0; e_alu = '0;
  endtask

  task automatic check_w();
    chk1 ("RegWriteW", RegWriteW, e_rw);
    chk1 ("MemtoRegW", MemtoRegW, e_m2r);
    chk32("WriteRegW", {27'd0, WriteRegW}, {27'd0, e_wr});
    chk32("ReadDataW", ReadDataW, e_rd);
    chk32("ALUOutW",   ALUOutW,   e_alu);
    chk32("ResultW",   ResultW,   e_m2r ? e_rd : e_alu);
  endtask

  // One instruction through MEM. For an access, k idle-ack cycles precede the ack (k <= TO);
  // a non-access op is driven with a spurious ack that must be ignored.
  task automatic run_op(input logic rw, input logic m2r, input logic mw, input logic [4:0] wr,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] rdata,
                        input int k);
    logic acc;
    int   last;
    acc  = m2r | mw;
    last = acc ? k : 0;
    RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    WriteRegM = wr; ALUOutM = alu; WriteDataM = wd;
    for (int c = 0; c <= last; c++) begin
      dmem_ack   = acc ? (c == last) : 1'b1;
      dmem_rdata = (c == last) ? rdata : $urandom;
      #1;
      chk1("dmem_req", dmem_req, acc);
      chk1("StallM",   StallM,   acc && (c != last));
      chk1("dmem_err", dmem_err, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
      chk1("misalign_err", misalign_err, 1'b0);
`endif
      if (acc) begin
        chk1 ("dmem_we",    dmem_we,    mw);
        chk32("dmem_addr",  dmem_addr,  alu);
        chk32("dmem_wdata", dmem_wdata, wd);
      end
      @(posedge clk); #1;
      if (c != last) begin
        e_rw = 1'b0; e_m2r = 1'b0;
      end else begin
        e_rw = rw; e_m2r = m2r; e_wr = wr; e_alu = alu;
        if (acc && !mw) e_rd = rdata;
      end
      check_w();
    end
  endtask

  task automatic drive_load_noack(input logic [31:0] alu);
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    WriteRegM = 5'd9; ALUOutM = alu; WriteDataM = $urandom;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
  endtask

  initial begin
    int          kind;
    logic [31:0] a;

    // Reset with a pending load on the inputs: nothing may be requested or stalled.
    rst = 1'b1;
    drive_load_noack(32'h100);
    #1;
    chk1("rst_req",   dmem_req, 1'b0);
    chk1("rst_stall", StallM,   1'b0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_w();
    chk1("rst_err", dmem_err, 1'b0);
    rst = 1'b0;

    // Plain ALU op, zero-wait load, store acked after three stalled cycles.
    run_op(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 32'h1111_2222, 0);
    run_op(1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0);
    run_op(1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0080, 32'hA5A5_A5A5, 32'h5555_0000, 3);
    run_op(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_00C0, 32'h0, 32'h0BAD_F00D, TO);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      a    = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      a[1:0] = 2'b00;
`endif
      run_op(1'($urandom_range(0, 1)), (kind == 1) || (kind == 3), kind >= 2,
             5'($urandom), a, $urandom, $urandom, int'($urandom_range(0, TO)));
    end

    // Reset during the 2nd WAIT cycle abandons the load; a later ack is ignored.
    drive_load_noack(32'h200);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk1("mw_req",   dmem_req, 1'b1);
      chk1("mw_stall", StallM,   1'b1);
      @(posedge clk); #1;
      e_rw = 1'b0; e_m2r = 1'b0;
      check_w();
    end
    rst = 1'b1;
    #1;
    chk1("mw_rst_req",   dmem_req, 1'b0);
    chk1("mw_rst_stall", StallM,   1'b0);
    @(posedge clk); #1;
    model_reset();
    check_w();
    rst = 1'b0;
    run_op(1'b1, 1'b0, 1'b0, 5'd2, 32'h0000_0300, 32'h0, 32'hFFFF_FFFF, 0);

    // Timeout: TO WAIT cycles without ack are tolerated, then ERROR until reset.
    drive_load_noack(32'h400);
    for (int c = 0; c <= int'(TO); c++) begin
      #1;
      chk1("to_req",   dmem_req, 1'b1);
      chk1("to_stall", StallM,   1'b1);
      chk1("to_err",   dmem_err, 1'b0);
      @(posedge clk); #1;
      e_rw = 1'b0; e_m2r = 1'b0;
      check_w();
    end
    dmem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1("err_req",   dmem_req, 1'b0);
      chk1("err_stall", StallM,   1'b1);
      chk1("err_flag",  dmem_err, 1'b1);
      @(posedge clk); #1;
      check_w();
    end
    rst = 1'b1;
    #1;
    chk1("err_rst_req",   dmem_req, 1'b0);
    chk1("err_rst_stall", StallM,   1'b0);
    @(posedge clk); #1;
    model_reset();
    check_w();
    chk1("err_rst_flag", dmem_err, 1'b0);
    rst = 1'b0;
    run_op(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0500, 32'h0, 32'h1357_9BDF, 1);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned load completes at once with no request and a zeroed, non-writing result.
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    WriteRegM = 5'd6; ALUOutM = 32'h41; dmem_ack = 1'b0; dmem_rdata = $urandom;
    #1;
    chk1("mis_req",   dmem_req,     1'b0);
    chk1("mis_stall", StallM,       1'b0);
    chk1("mis_pulse", misalign_err, 1'b1);
    @(posedge clk); #1;
    e_rw = 1'b0; e_m2r = 1'b1; e_wr = 5'd6; e_alu = 32'h41; e_rd = 32'h0;
    check_w();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16: the maximum number of WAIT cycles allowed without dmem_ack before the ERROR state, legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 RegWriteM, MemtoRegM, MemWriteM  input  1 each  EX/MEM control bits.
REQ-005 WriteRegM  input  5  destination register; ALUOutM  input  32  address/ALU result; WriteDataM  input  32  store data.
REQ-006 dmem_req  output  1, dmem_we  output  1, dmem_addr  output  32, dmem_wdata  output  32  data-memory request bus.
REQ-007 dmem_rdata  input  32, dmem_ack  input  1  data-memory response, valid when dmem_ack=1.
REQ-008 StallM  output  1  freeze request to upstream stages; dmem_err  output  1  sticky timeout flag.
REQ-009 RegWriteW, MemtoRegW  output  1 each, WriteRegW  output  5, ReadDataW, ALUOutW  output  32 each  MEM/WB register outputs.
REQ-010 ResultW  output  32  writeback/forwarding value: ReadDataW when MemtoRegW=1, else ALUOutW (combinational).

Function
REQ-011 The access condition SHALL be MemtoRegM OR MemWriteM; MemWriteM=1 SHALL select a store and otherwise a load.
REQ-012 FSM states SHALL be IDLE, WAIT, ERROR.
REQ-013 In IDLE with access, dmem_req SHALL be 1 in the same cycle; dmem_we=MemWriteM, dmem_addr=ALUOutM, dmem_wdata=WriteDataM.
REQ-014 In IDLE with access and dmem_ack=1 (zero-wait): StallM=0, state stays IDLE, MEM/WB captures on that edge.
REQ-015 In IDLE with access and dmem_ack=0: StallM=1 and the next state is WAIT with the wait counter cleared.
REQ-016 In WAIT: dmem_req=1 and the bus is driven from the EX/MEM inputs, which the upstream SHALL hold stable while StallM=1.
REQ-017 In WAIT with dmem_ack=1: StallM=0, MEM/WB captures, next state IDLE.
REQ-018 In WAIT without ack, the counter SHALL increment; when it reaches ACK_TIMEOUT-1 without ack, the next state SHALL be ERROR.
REQ-019 In ERROR: dmem_req=0, StallM=1, dmem_err=1; exit only by reset; dmem_ack ignored.
REQ-020 dmem_ack while no request is outstanding SHALL be ignored.
REQ-021 On a capture edge: RegWriteW<=RegWriteM, MemtoRegW<=MemtoRegM, WriteRegW<=WriteRegM, ALUOutW<=ALUOutM.
REQ-022 On a capture edge, ReadDataW<=dmem_rdata for a load; otherwise ReadDataW SHALL hold its value.
REQ-023 With no access in IDLE, MEM/WB SHALL capture every edge with no stall (latency 1 cycle).
REQ-024 While StallM=1, MEM/WB SHALL load a bubble: RegWriteW=0, MemtoRegW=0, other fields hold.
REQ-025 A store SHALL complete with RegWriteW as supplied, normally 0.

Reset
REQ-026 On rst=1 at a clock edge: state<=IDLE, counter<=0, dmem_err<=0, RegWriteW<=0, MemtoRegW<=0, WriteRegW<=0, ReadDataW<=0, ALUOutW<=0.
REQ-027 While rst=1, dmem_req and StallM SHALL be forced to 0, including when reset arrives mid-WAIT or in ERROR; an outstanding access is abandoned.

Configuration
REQ-028 Macro MEM_ALIGN_CHECK_EN, when defined: an access with ALUOutM[1:0]!=0 SHALL issue no request and no stall.
REQ-029 With MEM_ALIGN_CHECK_EN defined, such an access SHALL capture in one cycle with RegWriteW forced to 0 and ReadDataW<=0.
REQ-030 With MEM_ALIGN_CHECK_EN defined, a misaligned access SHALL pulse output misalign_err for that cycle.
REQ-031 When MEM_ALIGN_CHECK_EN is undefined, the misalign_err port and the alignment check SHALL be absent, and every access SHALL be issued unmodified.

Verification
REQ-032 Non-memory op: ALUOutM=0x1234, RegWriteM=1, WriteRegM=5 -> next cycle ALUOutW=0x1234, RegWriteW=1, ResultW=0x1234, StallM never 1.
REQ-033 Zero-wait load: ALUOutM=0x40, dmem_ack=1, dmem_rdata=0xDEADBEEF -> dmem_req=1 for one cycle, next cycle ReadDataW=0xDEADBEEF, ResultW=0xDEADBEEF.
REQ-034 Store, ack after 3 cycles: WriteDataM=0xA5A5A5A5 -> StallM=1 for 3 cycles, dmem_we=1 with stable wdata throughout, RegWriteW=0 during the bubble, IDLE after the ack.
REQ-035 Timeout: load with no ack -> ERROR after ACK_TIMEOUT cycles, dmem_err=1, StallM held; rst -> dmem_err=0, IDLE, dmem_req=0.
REQ-036 Reset mid-WAIT: assert rst during the 2nd wait cycle -> dmem_req=0 in that cycle, all W outputs 0 after the edge, and a later ack is ignored.
REQ-037 With MEM_ALIGN_CHECK_EN defined, load at ALUOutM=0x41 -> dmem_req=0, misalign_err pulse, RegWriteW=0, ReadDataW=0.
